pipe_control: RTL

//  Pipelined successor to the single-cycle control decoder: decodes InstrD in ID, carries control through
//  ID/EX, EX/MEM and MEM/WB registers, and resolves branches/jumps in EX. Contains the hazard unit:

---
 rtl/pipe_control_if.sv | 35 +++
 rtl/pipe_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_if.sv
// Control-path bundle between the 5-stage datapath (master) and pipe_control (slave).
interface pipe_control_if #(
  parameter int A_WIDTH = 32,
  parameter int R_WIDTH = 5
);
  logic [A_WIDTH-1:0] InstrD;
  logic               ZeroE;
  logic [2:0]         ImmSrcD;
  logic [3:0]         ALUControlE;
  logic               ALUSrcE;
  logic               PCSrcE;
  logic               JalrE;
  logic               MemWriteM;
  logic               RegWriteW;
  logic [1:0]         ResultSrcW;
  logic [R_WIDTH-1:0] RdW;
  logic               StallF;
  logic               StallD;
  logic               FlushD;
  logic               FlushE;
  logic [1:0]         ForwardAE;
  logic [1:0]         ForwardBE;

  modport master (
    output InstrD, ZeroE,
    input  ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, JalrE, MemWriteM, RegWriteW,
           ResultSrcW, RdW, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  InstrD, ZeroE,
    output ImmSrcD, ALUControlE, ALUSrcE, PCSrcE, JalrE, MemWriteM, RegWriteW,
           ResultSrcW, RdW, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/pipe_control.sv
// Pipelined RV32 control: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// EX branch resolution and the hazard unit (load-use stall, flush, forwarding).
module pipe_control #(
  parameter int A_WIDTH    = 32,
  parameter int R_WIDTH    = 5,
  parameter bit FORWARD_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  pipe_control_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                         ALU_SLL = 4'b0110, ALU_SRL = 4'b0111, ALU_SRA = 4'b1000;

  logic [6:0]         op;
  logic [2:0]         fn3_d;
  logic               fn7_5;
  logic [R_WIDTH-1:0] rs1_d, rs2_d, rd_d;
  logic               unused_instr_bits;

  assign op    = bus.InstrD[6:0];
  assign rd_d  = bus.InstrD[7 +: R_WIDTH];
  assign fn3_d = bus.InstrD[14:12];
  assign rs1_d = bus.InstrD[15 +: R_WIDTH];
  assign rs2_d = bus.InstrD[20 +: R_WIDTH];
  assign fn7_5 = bus.InstrD[30];
  assign unused_instr_bits = ^{bus.InstrD[31], bus.InstrD[29:25]};

  logic       reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d, jalr_d, alu_fn_d;
  logic [1:0] result_src_d;
  logic [3:0] alu_control_d;
  logic [2:0] imm_src_d;

  always_comb begin
    reg_write_d   = 1'b0;
    mem_write_d   = 1'b0;
    alu_src_d     = 1'b0;
    branch_d      = 1'b0;
    jump_d        = 1'b0;
    jalr_d        = 1'b0;
    alu_fn_d      = 1'b0;
    result_src_d  = 2'b00;
    alu_control_d = ALU_ADD;
    imm_src_d     = 3'b000;
    case (op)
      OP_R:      begin reg_write_d = 1'b1; alu_fn_d = 1'b1; end
      OP_I:      begin reg_write_d = 1'b1; alu_src_d = 1'b1; alu_fn_d = 1'b1; end
      OP_LOAD:   begin reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01; end
      OP_STORE:  begin mem_write_d = 1'b1; alu_src_d = 1'b1; imm_src_d = 3'b001; end
      OP_BRANCH: begin branch_d = 1'b1; alu_control_d = ALU_SUB; imm_src_d = 3'b010; end
      OP_JAL:    begin reg_write_d = 1'b1; jump_d = 1'b1; result_src_d = 2'b10; imm_src_d = 3'b011; end
      OP_JALR:   begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        jalr_d       = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 2'b10;
      end
      OP_LUI:    begin reg_write_d = 1'b1; result_src_d = 2'b11; imm_src_d = 3'b100; end
      default:   ;
    endcase
    // fn7[5] only turns add into sub for R-type; immediates reuse that bit otherwise
    if (alu_fn_d) begin
      case (fn3_d)
        3'b000:  alu_control_d = (op == OP_R && fn7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_control_d = ALU_SLL;
        3'b010:  alu_control_d = ALU_SLT;
        3'b011:  alu_control_d = ALU_SLT;
        3'b100:  alu_control_d = ALU_XOR;
        3'b101:  alu_control_d = fn7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_control_d = ALU_OR;
        default: alu_control_d = ALU_AND;
      endcase
    end
  end

  logic               reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e, jalr_e;
  logic [1:0]         result_src_e;
  logic [3:0]         alu_control_e;
  logic [2:0]         fn3_e;
  logic [R_WIDTH-1:0] rs1_e, rs2_e, rd_e;
  logic               flush_e, pc_src_e, taken_e, stall;

  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      alu_src_e     <= 1'b0;
      branch_e      <= 1'b0;
      jump_e        <= 1'b0;
      jalr_e        <= 1'b0;
      result_src_e  <= 2'b00;
      alu_control_e <= 4'b0000;
      fn3_e         <= 3'b000;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
    end else begin
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      alu_src_e     <= alu_src_d;
      branch_e      <= branch_d;
      jump_e        <= jump_d;
      jalr_e        <= jalr_d;
      result_src_e  <= result_src_d;
      alu_control_e <= alu_control_d;
      fn3_e         <= fn3_d;
      rs1_e         <= rs1_d;
      rs2_e         <= rs2_d;
      rd_e          <= rd_d;
    end
  end

  logic               reg_write_m, mem_write_m, reg_write_w;
  logic [1:0]         result_src_m, result_src_w;
  logic [R_WIDTH-1:0] rd_m, rd_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      rd_m         <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= '0;
    end else begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      rd_m         <= rd_e;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

  logic match_e, match_m, load_use, raw_stall;

  always_comb begin
    case (fn3_e)
      3'b000:  taken_e = bus.ZeroE;
      3'b001:  taken_e = ~bus.ZeroE;
      default: taken_e = 1'b0;
    endcase
    pc_src_e  = (branch_e & taken_e) | jump_e;
    match_e   = (rd_e != '0) && (rd_e == rs1_d || rd_e == rs2_d);
    match_m   = (rd_m != '0) && (rd_m == rs1_d || rd_m == rs2_d);
    load_use  = (result_src_e == 2'b01) && match_e;
    raw_stall = !FORWARD_EN && ((reg_write_e && match_e) || (reg_write_m && match_m));
    // A taken branch/jump discards the stalled instruction anyway, so flush wins
    stall     = (load_use || raw_stall) && !pc_src_e;
    flush_e   = stall || pc_src_e;
  end

  always_comb begin
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    if (FORWARD_EN) begin
      if (reg_write_m && rd_m != '0 && rd_m == rs1_e)      bus.ForwardAE = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs1_e) bus.ForwardAE = 2'b01;
      if (reg_write_m && rd_m != '0 && rd_m == rs2_e)      bus.ForwardBE = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs2_e) bus.ForwardBE = 2'b01;
    end
  end

  assign bus.ImmSrcD     = imm_src_d;
  assign bus.ALUControlE = alu_control_e;
  assign bus.ALUSrcE     = alu_src_e;
  assign bus.PCSrcE      = pc_src_e;
  assign bus.JalrE       = jalr_e;
  assign bus.MemWriteM   = mem_write_m;
  assign bus.RegWriteW   = reg_write_w;
  assign bus.ResultSrcW  = result_src_w;
  assign bus.RdW         = rd_w;
  assign bus.StallF      = stall;
  assign bus.StallD      = stall;
  assign bus.FlushD      = pc_src_e;
  assign bus.FlushE      = flush_e;
endmodule
